// File: rtl/sigma_delta1.sv
// First-order sigma-delta modulator: a signed sample is offset to unsigned and
// accumulated once per prescaled step; the accumulator carry is the output bit.
module sigma_delta1 #(
  parameter int n   = 16,
  parameter int div = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic signed [n-1:0] in,
  input  logic                strb,
  output logic                out,
  output logic                tick
);

  localparam int cw = (div > 1) ? $clog2(div) : 1;

  logic signed [n-1:0] sample;
  logic [cw-1:0]       cnt;
  logic [n-1:0]        acc;
  logic [n-1:0]        u;
  logic [n:0]          sum;
  logic                step;

  // Flipping the sign bit maps -2^(n-1)..2^(n-1)-1 onto 0..2^n-1.
  assign u    = {~sample[n-1], sample[n-2:0]};
  assign sum  = {1'b0, acc} + {1'b0, u};
  assign step = (cnt == cw'(div - 1));

  // The step reads the pre-edge sample, so a strobe coinciding with a step
  // only takes effect on the following step; acc is never cleared by strb.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample <= '0;
      cnt    <= '0;
      acc    <= '0;
      out    <= 1'b0;
      tick   <= 1'b0;
    end else begin
      if (strb) sample <= in;
      cnt  <= step ? '0 : cnt + cw'(1);
      tick <= step;
      if (step) begin
        acc <= sum[n-1:0];
        out <= sum[n];
      end
    end
  end

endmodule
